// File: rtl/isp_pattern_gen_if.sv
// Video output bundle of the ISP test-pattern generator: sync/valid strobes,
// RGB pixel channels and frame bookkeeping.
interface isp_pattern_gen_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  post_frame_vsync;
   logic                  post_frame_hsync;
   logic                  post_frame_href;
   logic [DATA_WIDTH-1:0] post_img_red;
   logic [DATA_WIDTH-1:0] post_img_green;
   logic [DATA_WIDTH-1:0] post_img_blue;
   logic                  frame_done;
   logic [7:0]            frame_cnt;

   modport master (
      output post_frame_vsync,
      output post_frame_hsync,
      output post_frame_href,
      output post_img_red,
      output post_img_green,
      output post_img_blue,
      output frame_done,
      output frame_cnt
   );

   modport slave (
      input post_frame_vsync,
      input post_frame_hsync,
      input post_frame_href,
      input post_img_red,
      input post_img_green,
      input post_img_blue,
      input frame_done,
      input frame_cnt
   );
endinterface

// File: rtl/isp_pattern_gen.sv
// Raster timing generator with four selectable test patterns; every output is
// registered one clock behind the horizontal/vertical counter state.
module isp_pattern_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int H_SYNC     = 1,
   parameter int H_BP       = 1,
   parameter int H_ACTIVE   = 8,
   parameter int H_FP       = 2,
   parameter int V_SYNC     = 1,
   parameter int V_BP       = 1,
   parameter int V_ACTIVE   = 10,
   parameter int V_FP       = 1,
   parameter bit HS_POL     = 1'b1,
   parameter bit VS_POL     = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [1:0]          pattern_sel,
   isp_pattern_gen_if.master   video
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int H_START = H_SYNC + H_BP;
   localparam int H_END   = H_START + H_ACTIVE;
   localparam int V_START = V_SYNC + V_BP;
   localparam int V_END   = V_START + V_ACTIVE;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                state_reg, state_next;
   logic [HW-1:0]         hcnt_reg, hcnt_next;
   logic [VW-1:0]         vcnt_reg, vcnt_next;
   logic [1:0]            pat_reg, pat_next;
   logic [7:0]            fc_frame_reg, fc_frame_next;
   logic [7:0]            frame_cnt_reg, frame_cnt_next;

   logic                  hsync_reg, hsync_next;
   logic                  vsync_reg, vsync_next;
   logic                  href_reg, href_next;
   logic [DATA_WIDTH-1:0] red_reg, red_next;
   logic [DATA_WIDTH-1:0] green_reg, green_next;
   logic [DATA_WIDTH-1:0] blue_reg, blue_next;
   logic                  frame_done_reg, frame_done_next;

   logic [31:0]           h_ext, v_ext, x, y;
   logic                  raw_hsync, raw_vsync, raw_href;
   logic                  line_end, frame_end, frame_start;
   logic [2:0]            bar;
   logic [2:0]            pal;
   logic [2:0]            bar_palette [8];
   logic [DATA_WIDTH-1:0] pix_r, pix_g, pix_b;

   // Bar colours as {R,G,B} on/off bits: white, yellow, cyan, green,
   // magenta, red, blue, black.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_palette
         localparam logic [2:0] IDX = 3'(gi);
         assign bar_palette[gi] = {~IDX[1], ~IDX[2], ~IDX[0]};
      end
   endgenerate

   assign h_ext       = 32'(hcnt_reg);
   assign v_ext       = 32'(vcnt_reg);
   assign x           = h_ext - 32'(H_START);
   assign y           = v_ext - 32'(V_START);
   assign bar         = 3'(x / 32'(BAR_W));
   assign pal         = bar_palette[bar];

   assign raw_hsync   = h_ext < 32'(H_SYNC);
   assign raw_vsync   = v_ext < 32'(V_SYNC);
   assign raw_href    = (h_ext >= 32'(H_START)) && (h_ext < 32'(H_END)) &&
                        (v_ext >= 32'(V_START)) && (v_ext < 32'(V_END));

   assign line_end    = (hcnt_reg == H_LAST);
   assign frame_end   = line_end && (vcnt_reg == V_LAST);
   assign frame_start = (hcnt_reg == '0) && (vcnt_reg == '0);

   // The frame-start cycle is always inside hsync, so pixels never see the
   // pattern/frame-count registers before they have been latched for the frame.
   always_comb begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      case (pat_reg)
         2'd0: begin
            pix_r = {DATA_WIDTH{pal[2]}};
            pix_g = {DATA_WIDTH{pal[1]}};
            pix_b = {DATA_WIDTH{pal[0]}};
         end
         2'd1: begin
            pix_r = DATA_WIDTH'(x);
            pix_g = DATA_WIDTH'(x);
            pix_b = DATA_WIDTH'(x);
         end
         2'd2: begin
            pix_r = {DATA_WIDTH{x[3] ^ y[3]}};
            pix_g = {DATA_WIDTH{x[3] ^ y[3]}};
            pix_b = {DATA_WIDTH{x[3] ^ y[3]}};
         end
         default: begin
            pix_r = DATA_WIDTH'(x + 32'(fc_frame_reg));
            pix_g = DATA_WIDTH'(y + 32'(fc_frame_reg));
            pix_b = DATA_WIDTH'(fc_frame_reg);
         end
      endcase
   end

   always_comb begin
      state_next      = state_reg;
      hcnt_next       = hcnt_reg;
      vcnt_next       = vcnt_reg;
      pat_next        = pat_reg;
      fc_frame_next   = fc_frame_reg;
      frame_cnt_next  = frame_cnt_reg;
      hsync_next      = ~HS_POL;
      vsync_next      = ~VS_POL;
      href_next       = 1'b0;
      red_next        = '0;
      green_next      = '0;
      blue_next       = '0;
      frame_done_next = 1'b0;

      case (state_reg)
         IDLE: begin
            hcnt_next = '0;
            vcnt_next = '0;
            if (enable) begin
               state_next = RUN;
            end
         end

         RUN: begin
            if (line_end) begin
               hcnt_next = '0;
               vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
            end else begin
               hcnt_next = hcnt_reg + 1'b1;
            end

            // Stopping is only honoured on the last pixel so frames stay whole.
            if (frame_end && !enable) begin
               state_next = IDLE;
            end

            if (frame_start) begin
               pat_next      = pattern_sel;
               fc_frame_next = frame_cnt_reg;
            end

            hsync_next = raw_hsync ? HS_POL : ~HS_POL;
            vsync_next = raw_vsync ? VS_POL : ~VS_POL;
            href_next  = raw_href;
            if (raw_href) begin
               red_next   = pix_r;
               green_next = pix_g;
               blue_next  = pix_b;
            end

            if (frame_end) begin
               frame_done_next = 1'b1;
               frame_cnt_next  = frame_cnt_reg + 8'd1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         hcnt_reg       <= '0;
         vcnt_reg       <= '0;
         pat_reg        <= 2'd0;
         fc_frame_reg   <= 8'd0;
         frame_cnt_reg  <= 8'd0;
         hsync_reg      <= ~HS_POL;
         vsync_reg      <= ~VS_POL;
         href_reg       <= 1'b0;
         red_reg        <= '0;
         green_reg      <= '0;
         blue_reg       <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         hcnt_reg       <= hcnt_next;
         vcnt_reg       <= vcnt_next;
         pat_reg        <= pat_next;
         fc_frame_reg   <= fc_frame_next;
         frame_cnt_reg  <= frame_cnt_next;
         hsync_reg      <= hsync_next;
         vsync_reg      <= vsync_next;
         href_reg       <= href_next;
         red_reg        <= red_next;
         green_reg      <= green_next;
         blue_reg       <= blue_next;
         frame_done_reg <= frame_done_next;
      end
   end

   assign video.post_frame_hsync = hsync_reg;
   assign video.post_frame_vsync = vsync_reg;
   assign video.post_frame_href  = href_reg;
   assign video.post_img_red     = red_reg;
   assign video.post_img_green   = green_reg;
   assign video.post_img_blue    = blue_reg;
   assign video.frame_done       = frame_done_reg;
   assign video.frame_cnt        = frame_cnt_reg;

endmodule

// File: tb/tb_isp_pattern_gen.sv
// Directed bench for isp_pattern_gen at default geometry (12 x 13 = 156 clocks
// per frame); outputs are sampled on the falling edge.
module tb_isp_pattern_gen;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [1:0] pattern_sel;

   int n_cmp = 0;
   int n_err = 0;
   int cur_k = 0;

   logic [23:0] bars [8];

   isp_pattern_gen_if #(.DATA_WIDTH(8)) vif ();

   isp_pattern_gen dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .video       (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s @k=%0d: observed %0h required %0h", tag, cur_k, obs, expv);
      end
   endtask

   function automatic logic [23:0] pix_exp(input int pat, input int x, input int y, input int fc);
      case (pat)
         0:       return bars[x];
         1:       return {3{8'(x)}};
         2:       return ((((x / 8) ^ (y / 8)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
         default: return {8'((x + fc) & 255), 8'((y + fc) & 255), 8'(fc & 255)};
      endcase
   endfunction

   // run=0: idle levels expected. run=1: outputs for counter state kk of a frame.
   task automatic check_cycle(input bit run, input int kk, input int pat,
                              input int fcf, input int fcb);
      int h, v;
      bit ehs, evs, ehref, efd;
      logic [23:0] ergb;
      int efc;
      cur_k = kk;
      ehs = 1'b0; evs = 1'b1; ehref = 1'b0; efd = 1'b0; ergb = 24'h0; efc = fcb & 255;
      if (run) begin
         h     = kk % 12;
         v     = kk / 12;
         ehs   = (h < 1);
         evs   = !(v < 1);
         ehref = (h >= 2) && (h < 10) && (v >= 2) && (v < 12);
         if (ehref) ergb = pix_exp(pat, h - 2, v - 2, fcf);
         efd   = (kk == 155);
         efc   = (fcb + (efd ? 1 : 0)) & 255;
      end
      check("hsync", 32'(vif.post_frame_hsync), 32'(ehs));
      check("vsync", 32'(vif.post_frame_vsync), 32'(evs));
      check("href", 32'(vif.post_frame_href), 32'(ehref));
      check("rgb", 32'({vif.post_img_red, vif.post_img_green, vif.post_img_blue}), 32'(ergb));
      check("frame_done", 32'(vif.frame_done), 32'(efd));
      check("frame_cnt", 32'(vif.frame_cnt), 32'(efc));
   endtask

   initial begin
      int href_cnt;
      int first_href;
      int t;
      int last_fd;
      int fd_cnt;

      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

      // Reset state
      rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
      repeat (3) @(negedge clk);
      check_cycle(1'b0, 0, 0, 0, 0);

      // Bars frame, then pattern_sel -> 2 mid-frame; second frame is checkerboard
      rst = 1'b0; enable = 1'b1;
      @(negedge clk);
      check_cycle(1'b0, 0, 0, 0, 0);
      @(negedge clk);
      href_cnt = 0; first_href = -1;
      for (int k = 0; k < 312; k++) begin
         check_cycle(1'b1, k % 156, (k < 156) ? 0 : 2, 0, k / 156);
         if (k < 156 && vif.post_frame_href === 1'b1) begin
            href_cnt++;
            if (first_href < 0) first_href = k;
         end
         if (k == 60) pattern_sel = 2'd2;
         @(negedge clk);
      end
      check("href_count", 32'(href_cnt), 32'd80);
      check("first_href", 32'(first_href), 32'd26);

      // Enable dropped mid-frame: frame completes, then idles
      for (int k = 0; k < 156; k++) begin
         check_cycle(1'b1, k, 2, 0, 2);
         if (k == 60) enable = 1'b0;
         @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
         check_cycle(1'b0, 0, 0, 0, 3);
         @(negedge clk);
      end

      // Gradient frame aborted by a one-clock reset around vcnt=6
      pattern_sel = 2'd1; enable = 1'b1;
      @(negedge clk);
      check_cycle(1'b0, 0, 0, 0, 3);
      @(negedge clk);
      for (int k = 0; k < 77; k++) begin
         check_cycle(1'b1, k, 1, 0, 3);
         @(negedge clk);
      end
      rst = 1'b1; pattern_sel = 2'd3;
      @(negedge clk);
      check_cycle(1'b0, 0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      check_cycle(1'b0, 0, 0, 0, 0);
      @(negedge clk);

      // Moving pattern for 256 frames: fixed period and frame_cnt wrap
      t = 0; last_fd = -1; fd_cnt = 0;
      for (int f = 0; f < 256; f++) begin
         for (int k = 0; k < 156; k++) begin
            check_cycle(1'b1, k, 3, f & 255, f & 255);
            if (vif.frame_done === 1'b1) begin
               if (last_fd >= 0) check("fd_interval", 32'(t - last_fd), 32'd156);
               last_fd = t;
               fd_cnt++;
            end
            if (f == 1 && k == 26)
               check("f2_first_pixel", 32'({vif.post_img_red, vif.post_img_green, vif.post_img_blue}), 32'h010101);
            t++;
            @(negedge clk);
         end
      end
      check("fd_count", 32'(fd_cnt), 32'd256);
      check("frame_cnt_wrap", 32'(vif.frame_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
